// File: rtl/fight_pkg.sv
// Shared encodings for the fight controller and the per-player character FSMs.
// Attack phase lengths live here so both sides agree on frame timing.
package fight_pkg;

  typedef enum logic [3:0] {
    S_IDLE                = 4'd0,
    S_LEFT                = 4'd1,
    S_RIGHT               = 4'd2,
    S_ATTACK_START        = 4'd3,
    S_ATTACK_ACTIVE       = 4'd4,
    S_ATTACK_RECOVERY     = 4'd5,
    S_ATTACK_DIR_START    = 4'd6,
    S_ATTACK_DIR_ACTIVE   = 4'd7,
    S_ATTACK_DIR_RECOVERY = 4'd8,
    S_STUN                = 4'd9
  } state_t;

  typedef enum logic [1:0] {
    S_NOHIT     = 2'd0,
    S_HITSTUN   = 2'd1,
    S_BLOCKSTUN = 2'd2
  } frame_state_t;

  localparam logic [4:0] ATK_START_LEN    = 5'd5;
  localparam logic [4:0] ATK_ACTIVE_LEN   = 5'd2;
  localparam logic [4:0] ATK_RECOVERY_LEN = 5'd16;
  localparam logic [4:0] DIR_START_LEN    = 5'd4;
  localparam logic [4:0] DIR_ACTIVE_LEN   = 5'd3;
  localparam logic [4:0] DIR_RECOVERY_LEN = 5'd15;
  localparam logic [4:0] CNT_MAX          = 5'd31;

  function automatic logic [4:0] sat_inc(input logic [4:0] v);
    return (v == CNT_MAX) ? v : v + 5'd1;
  endfunction

endpackage

// File: rtl/char_position.sv
// Registered character X position: steps left or right by the forward/back
// distance for this player and clamps to the arena bounds without wrapping.
module char_position
  import fight_pkg::*;
#(
  parameter bit         PLAYER    = 1'b0,
  parameter logic [9:0] X_INIT    = 10'd160,
  parameter logic [9:0] X_MIN     = 10'd32,
  parameter logic [9:0] X_MAX     = 10'd544,
  parameter int         FWD_STEP  = 3,
  parameter int         BACK_STEP = 2
)(
  input  logic       clk,
  input  logic       rst,
  input  logic       round_init,
  input  logic       step_en,
  input  logic       step_left,
  output logic [9:0] x_pos
);

  logic [10:0] step;
  logic [10:0] x_ext;
  logic [10:0] x_up;
  logic [10:0] x_dn;
  logic [9:0]  x_next;

  // Player 1 faces right, so moving left is a back step; player 2 is mirrored.
  always_comb begin
    step   = (step_left ^ (PLAYER != 1'b0)) ? 11'(BACK_STEP) : 11'(FWD_STEP);
    x_ext  = {1'b0, x_pos};
    x_up   = x_ext + step;
    x_dn   = x_ext - step;
    x_next = x_pos;
    if (step_en) begin
      if (step_left)
        x_next = (x_ext < ({1'b0, X_MIN} + step)) ? X_MIN : x_dn[9:0];
      else
        x_next = (x_up > {1'b0, X_MAX}) ? X_MAX : x_up[9:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)             x_pos <= X_INIT;
    else if (round_init) x_pos <= X_INIT;
    else                 x_pos <= x_next;
  end

endmodule

// File: rtl/char_fsm.sv
// Per-player character state machine: movement/attack phases, hit/block stun
// with a controller-supplied stun length, frame counter and X position.
module char_fsm
  import fight_pkg::*;
#(
  parameter bit         PLAYER    = 1'b0,
  parameter logic [9:0] X_INIT    = 10'd160,
  parameter logic [9:0] X_MIN     = 10'd32,
  parameter logic [9:0] X_MAX     = 10'd544,
  parameter int         FWD_STEP  = 3,
  parameter int         BACK_STEP = 2
)(
  input  logic       clk,
  input  logic       rst,
  input  logic       round_init,
  input  logic       input_active,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_attack,
  input  logic       hit_in,
  input  logic       block_in,
  input  logic [4:0] load_frame,
  output logic [3:0] state,
  output logic [1:0] frame_state,
  output logic [4:0] frame_counter,
  output logic [9:0] x_pos
);

  state_t       state_q, state_d, req;
  frame_state_t fs_q, fs_d;
  logic [4:0]   cnt_q, cnt_d;
  logic [4:0]   len_q, len_d;
  logic         restart;
  logic         one_dir;
  logic         step_en, step_left;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      fs_q    <= S_NOHIT;
      cnt_q   <= '0;
      len_q   <= '0;
    end else if (round_init) begin
      state_q <= S_IDLE;
      fs_q    <= S_NOHIT;
      cnt_q   <= '0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      fs_q    <= fs_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
    end
  end

  always_comb begin
    one_dir = btn_left ^ btn_right;
    if (!input_active)              req = S_IDLE;
    else if (btn_attack && one_dir) req = S_ATTACK_DIR_START;
    else if (btn_attack)            req = S_ATTACK_START;
    else if (one_dir)               req = btn_left ? S_LEFT : S_RIGHT;
    else                            req = S_IDLE;

    // The controller answers the stun with its length one frame late.
    len_d = len_q;
    if (state_q == S_STUN && cnt_q == 5'd1)
      len_d = (load_frame == 5'd0) ? 5'd1 : load_frame;

    state_d = state_q;
    fs_d    = fs_q;
    restart = 1'b0;
    if (hit_in) begin
      state_d = S_STUN;
      fs_d    = S_HITSTUN;
      restart = 1'b1;
    end else if (block_in) begin
      state_d = S_STUN;
      fs_d    = S_BLOCKSTUN;
      restart = 1'b1;
    end else begin
      case (state_q)
        S_IDLE, S_LEFT, S_RIGHT: state_d = req;
        S_ATTACK_START:
          if (cnt_q == ATK_START_LEN - 5'd1) state_d = S_ATTACK_ACTIVE;
        S_ATTACK_ACTIVE:
          if (cnt_q == ATK_ACTIVE_LEN - 5'd1) state_d = S_ATTACK_RECOVERY;
        S_ATTACK_RECOVERY:
          if (cnt_q == ATK_RECOVERY_LEN - 5'd1) state_d = req;
        S_ATTACK_DIR_START:
          if (cnt_q == DIR_START_LEN - 5'd1) state_d = S_ATTACK_DIR_ACTIVE;
        S_ATTACK_DIR_ACTIVE:
          if (cnt_q == DIR_ACTIVE_LEN - 5'd1) state_d = S_ATTACK_DIR_RECOVERY;
        S_ATTACK_DIR_RECOVERY:
          if (cnt_q == DIR_RECOVERY_LEN - 5'd1) state_d = req;
        S_STUN:
          if (cnt_q >= 5'd2 && cnt_q >= len_q) begin
            state_d = S_IDLE;
            fs_d    = S_NOHIT;
          end
        default: state_d = S_IDLE;
      endcase
    end

    cnt_d = (restart || state_d != state_q) ? 5'd0 : sat_inc(cnt_q);
  end

  always_comb begin
    step_en       = (state_q == S_LEFT) || (state_q == S_RIGHT);
    step_left     = (state_q == S_LEFT);
    state         = state_q;
    frame_state   = fs_q;
    frame_counter = cnt_q;
  end

  char_position #(
    .PLAYER    (PLAYER),
    .X_INIT    (X_INIT),
    .X_MIN     (X_MIN),
    .X_MAX     (X_MAX),
    .FWD_STEP  (FWD_STEP),
    .BACK_STEP (BACK_STEP)
  ) u_position (
    .clk        (clk),
    .rst        (rst),
    .round_init (round_init),
    .step_en    (step_en),
    .step_left  (step_left),
    .x_pos      (x_pos)
  );

endmodule

// File: tb/tb_char_fsm.sv
// Scoreboard bench for char_fsm (player 1 instance): directed scenarios then
// randomized frames, each predicted by a frame-level behavioural model.
module tb_char_fsm;
  import fight_pkg::*;

  localparam int XI = 160, XMIN = 32, XMAX = 544, FWD = 3, BACK = 2;

  logic       clk = 1'b0, rst = 1'b0, round_init = 1'b0, input_active = 1'b0;
  logic       btn_left = 1'b0, btn_right = 1'b0, btn_attack = 1'b0;
  logic       hit_in = 1'b0, block_in = 1'b0;
  logic [4:0] load_frame = '0;
  logic [3:0] state;
  logic [1:0] frame_state;
  logic [4:0] frame_counter;
  logic [9:0] x_pos;

  int checks = 0;
  int fails  = 0;

  typedef struct { int st; int fs; int cnt; int x; } exp_t;
  exp_t sb[$];

  int m_st, m_fs, m_cnt, m_len, m_x;

  char_fsm #(
    .PLAYER(1'b0), .X_INIT(10'd160), .X_MIN(10'd32), .X_MAX(10'd544),
    .FWD_STEP(3), .BACK_STEP(2)
  ) dut (
    .clk(clk), .rst(rst), .round_init(round_init), .input_active(input_active),
    .btn_left(btn_left), .btn_right(btn_right), .btn_attack(btn_attack),
    .hit_in(hit_in), .block_in(block_in), .load_frame(load_frame),
    .state(state), .frame_state(frame_state), .frame_counter(frame_counter),
    .x_pos(x_pos)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int phase_len(input int s);
    case (s)
      S_ATTACK_START:        return 5;
      S_ATTACK_ACTIVE:       return 2;
      S_ATTACK_RECOVERY:     return 16;
      S_ATTACK_DIR_START:    return 4;
      S_ATTACK_DIR_ACTIVE:   return 3;
      S_ATTACK_DIR_RECOVERY: return 15;
      default:               return 0;
    endcase
  endfunction

  function automatic int phase_next(input int s, input int rq);
    case (s)
      S_ATTACK_START:     return S_ATTACK_ACTIVE;
      S_ATTACK_ACTIVE:    return S_ATTACK_RECOVERY;
      S_ATTACK_DIR_START: return S_ATTACK_DIR_ACTIVE;
      S_ATTACK_DIR_ACTIVE:return S_ATTACK_DIR_RECOVERY;
      default:            return rq;
    endcase
  endfunction

  function automatic int request(input bit l, input bit r, input bit a, input bit ia);
    if (!ia) return S_IDLE;
    if (a && (l != r)) return S_ATTACK_DIR_START;
    if (a) return S_ATTACK_START;
    if (l && !r) return S_LEFT;
    if (r && !l) return S_RIGHT;
    return S_IDLE;
  endfunction

  task automatic model_reset();
    m_st = S_IDLE; m_fs = S_NOHIT; m_cnt = 0; m_len = 0; m_x = XI;
  endtask

  task automatic model_step(input bit l, input bit r, input bit a, input bit ia,
                            input bit h, input bit b, input int lf, input bit ri);
    int ns, nfs, ncnt, nlen, nx, rq;
    if (ri) begin
      model_reset();
      return;
    end
    nx = m_x;
    if (m_st == S_LEFT)       nx = (m_x - BACK < XMIN) ? XMIN : m_x - BACK;
    else if (m_st == S_RIGHT) nx = (m_x + FWD > XMAX) ? XMAX : m_x + FWD;
    nlen = (m_st == S_STUN && m_cnt == 1) ? ((lf == 0) ? 1 : lf) : m_len;
    rq   = request(l, r, a, ia);
    ns   = m_st;
    nfs  = m_fs;
    if (h || b) begin
      ns   = S_STUN;
      nfs  = h ? S_HITSTUN : S_BLOCKSTUN;
      ncnt = 0;
    end else begin
      if (m_st == S_IDLE || m_st == S_LEFT || m_st == S_RIGHT) ns = rq;
      else if (phase_len(m_st) > 0) begin
        if (m_cnt == phase_len(m_st) - 1) ns = phase_next(m_st, rq);
      end else if (m_cnt >= 2 && m_cnt >= m_len) begin
        ns  = S_IDLE;
        nfs = S_NOHIT;
      end
      ncnt = (ns != m_st) ? 0 : ((m_cnt == 31) ? 31 : m_cnt + 1);
    end
    m_st = ns; m_fs = nfs; m_cnt = ncnt; m_len = nlen; m_x = nx;
  endtask

  task automatic frame(input bit l, input bit r, input bit a, input bit ia,
                       input bit h, input bit b, input int lf, input bit ri);
    exp_t e;
    @(negedge clk);
    rst = 1'b0;
    btn_left = l; btn_right = r; btn_attack = a; input_active = ia;
    hit_in = h; block_in = b; load_frame = 5'(lf); round_init = ri;
    model_step(l, r, a, ia, h, b, lf, ri);
    e.st = m_st; e.fs = m_fs; e.cnt = m_cnt; e.x = m_x;
    sb.push_back(e);
  endtask

  task automatic idle(input int n, input int lf);
    repeat (n) frame(0, 0, 0, 1, 0, 0, lf, 0);
  endtask

  task automatic check_reset();
    chk("rst_state", int'(state), S_IDLE);
    chk("rst_frame_state", int'(frame_state), S_NOHIT);
    chk("rst_counter", int'(frame_counter), 0);
    chk("rst_x", int'(x_pos), XI);
  endtask

  // Reset asserted between edges must take effect before the next clock.
  task automatic async_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    #1 check_reset();
    model_reset();
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("state", int'(state), e.st);
        chk("frame_state", int'(frame_state), e.fs);
        chk("frame_counter", int'(frame_counter), e.cnt);
        chk("x_pos", int'(x_pos), e.x);
      end
    end
  end

  initial begin : driver
    model_reset();
    #2 rst = 1'b1;
    #1 check_reset();

    frame(0, 0, 1, 1, 0, 0, 0, 0);
    idle(25, 0);

    repeat (80) frame(1, 0, 0, 1, 0, 0, 0, 0);

    frame(0, 1, 1, 1, 0, 0, 0, 0);
    idle(25, 0);

    frame(0, 0, 1, 1, 0, 0, 0, 0);
    idle(1, 20);
    frame(0, 0, 0, 1, 1, 0, 20, 0);
    idle(25, 20);

    frame(0, 0, 0, 1, 1, 1, 10, 0);
    idle(3, 10);
    frame(0, 0, 0, 1, 0, 1, 10, 0);
    idle(14, 10);

    repeat (5) frame(0, 1, 1, 0, 0, 0, 0, 0);
    frame(0, 0, 0, 1, 0, 1, 0, 0);
    idle(6, 0);

    frame(0, 0, 1, 1, 0, 0, 0, 0);
    idle(10, 0);
    async_reset();

    repeat (81) frame(0, 1, 0, 1, 0, 0, 0, 0);
    frame(0, 1, 0, 1, 0, 0, 0, 1);
    repeat (140) frame(0, 1, 0, 1, 0, 0, 0, 0);
    frame(1, 0, 1, 1, 0, 0, 0, 0);
    idle(30, 0);

    repeat (3000) begin
      if ($urandom_range(0, 499) == 0) async_reset();
      frame(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            $urandom_range(0, 3) == 0, $urandom_range(0, 7) != 0,
            $urandom_range(0, 24) == 0, $urandom_range(0, 24) == 0,
            ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(0, 31)),
            $urandom_range(0, 199) == 0);
    end

    repeat (3) @(posedge clk);
    #2;
    if (sb.size() != 0) chk("scoreboard_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
